counter_bank: RTL
=================

COUNTER_BANK -- requirements
Module: counter_bank

Interface
REQ-001 Parameter NCH, default 3: number of channels, 1..8.
REQ-002 Parameter WIDTH, default 32: counter and data width, 8..32.
REQ-003 Port clk, input, 1: single system clock, all state on its rising edge.
REQ-004 Port rst_n, input, 1: asynchronous active-low reset.
REQ-005 Port ch_tick, input, NCH: per-channel count-event inputs, asynchronous to clk, sampled and synchronised internally.
REQ-006 Port counter_we, input, 1: write strobe, one write per cycle.
REQ-007 Port counter_sel, input, 1: write target; 0 = count/load value, 1 = control word.
REQ-008 Port counter_ch, input, 3: channel select for both writes and reads.
REQ-009 Port counter_val, input, WIDTH: write data.
REQ-010 Port counter_OUT, output, NCH: per-channel registered output.
REQ-011 Port counter_out, output, WIDTH: combinational read of the selected channel's current count.

Function
REQ-012 Each channel holds load[WIDTH], count[WIDTH], mode[2], out[1].
REQ-013 Modes: 00 STOP (no counting); 01 ONESHOT; 10 PERIODIC; 11 SQUARE.
REQ-014 Tick path: ch_tick passes through 3 flops (s1, s2, s3); tick pulse = s2 & ~s3, one clk cycle per rising edge of ch_tick.
REQ-015 Latency: ch_tick first sampled high at edge k changes count at edge k+2.
REQ-016 Value write (we=1, sel=0): load = count = counter_val; out = 0; takes effect at the next edge.
REQ-017 Control write (we=1, sel=1): mode = counter_val[1:0]; count, load and out are unchanged.
REQ-018 A tick pulse in STOP mode, or with count = 0 in ONESHOT mode, has no effect.
REQ-019 A tick pulse with count > 1 decrements count by 1.
REQ-020 A tick pulse with count = 1 acts by mode:
- ONESHOT: count = 0, out = 1; out holds until the next value write.
- PERIODIC: count = load, out = 1 for exactly one clk cycle.
- SQUARE: count = load, out toggles.
REQ-021 PERIODIC or SQUARE with load = 0: the channel holds count = 0 and out is unchanged; no wrap to all-ones.
REQ-022 A write and a tick pulse on the same channel in the same cycle: the write wins and the tick is discarded. Ticks on other channels proceed normally.
REQ-023 counter_ch >= NCH: writes are ignored and counter_out = 0.
REQ-024 A value write while counting restarts the channel from the new value with no leftover output pulse.
REQ-025 counter_out = count[counter_ch], with no register stage.

Reset
REQ-026 While rst_n = 0, asynchronously: all count, load and out = 0; all mode = STOP; all sync flops = 0.
REQ-027 Reset deassertion has no synchroniser of its own; the first tick is recognised no earlier than 2 edges after rst_n rises.
REQ-028 Reset asserted mid-count aborts the count with no output pulse; the channel requires new writes afterwards.

Structure
REQ-029 Package counter_bank_pkg holds:
- mode encodings MODE_STOP, MODE_ONESHOT, MODE_PERIODIC, MODE_SQUARE;
- SEL_VALUE and SEL_CTRL;
- the channel-select width constant.
REQ-030 One sub-module, counter_bank_ch, holds the synchroniser, counter and output logic for one channel. It is instantiated NCH times by a generate loop.
REQ-031 The top level contains only write decode, the read mux and the generate loop.

Verification
REQ-032 Reset value check: hold rst_n = 0, then release -> counter_OUT = 0; counter_out = 0 for every channel; no tick has effect while mode = STOP.
REQ-033 ONESHOT: on ch0, value write 16'h10, control write 01, apply 16 tick edges. Required: counter_out goes 16 -> 0, counter_OUT[0] rises 2 cycles after the 16th tick edge and stays high; a 17th tick has no effect.
REQ-034 PERIODIC: on ch1, load 3, mode 10, apply 9 ticks. Required: exactly 3 one-cycle pulses on counter_OUT[1], count sequence 3, 2, 1, 3, ...
REQ-035 SQUARE: on ch2, load 2, mode 11, apply 8 ticks. Required: counter_OUT[2] toggles every 2nd tick, giving 2 full periods.
REQ-036 Collision: on ch0, write value 5 in the same cycle as a tick pulse. Required: count = 5, not 4. Also: write with counter_ch = 7 and NCH = 3 -> no state change, counter_out = 0.
REQ-037 Reset mid-count: assert rst_n low asynchronously between clk edges with ch1 at count 2 in PERIODIC. Required: outputs clear immediately; after release, ch1 is in STOP with count 0.

Source files
------------

// File: rtl/counter_bank_pkg.sv
// Shared encodings for the counter bank: channel modes, write-target select
// and the width of the channel-select field.
package counter_bank_pkg;

  typedef enum logic [1:0] {
    MODE_STOP     = 2'b00,
    MODE_ONESHOT  = 2'b01,
    MODE_PERIODIC = 2'b10,
    MODE_SQUARE   = 2'b11
  } mode_e;

  localparam logic SEL_VALUE = 1'b0;
  localparam logic SEL_CTRL  = 1'b1;

  localparam int CH_W = 3;

endpackage

// File: rtl/counter_bank_ch.sv
// One counter channel: tick synchroniser with rising-edge detect, down-counter
// with STOP/ONESHOT/PERIODIC/SQUARE behaviour, and the registered output bit.
module counter_bank_ch
  import counter_bank_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick_raw,
  input  logic             we,
  input  logic             sel,
  input  logic [WIDTH-1:0] val,
  output logic [WIDTH-1:0] count,
  output logic             out
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic       s1, s2, s3;
  logic       tick;
  logic [WIDTH-1:0] load;
  mode_e      mode;
  logic       pulse;  // out is a one-cycle PERIODIC pulse to be cleared

  // NOTE: every register, including the synchroniser flops, takes the async
  // reset so that reset mid-count leaves no stale tick or pending pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= tick_raw;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign tick = s2 & ~s3;

  // NOTE: non-blocking assignments throughout; a later assignment in the same
  // edge overrides the default pulse clear below.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load  <= '0;
      count <= '0;
      mode  <= MODE_STOP;
      out   <= 1'b0;
      pulse <= 1'b0;
    end else begin
      pulse <= 1'b0;
      if (pulse) out <= 1'b0;

      if (we && sel == SEL_VALUE) begin
        load  <= val;
        count <= val;
        out   <= 1'b0;
      end else if (we) begin
        mode <= mode_e'(val[1:0]);
      end else if (tick && mode != MODE_STOP) begin
        if (count > ONE) begin
          count <= count - ONE;
        end else if (count == ONE) begin
          // count = 0 (finished ONESHOT, or load = 0) falls through: no wrap
          unique case (mode)
            MODE_ONESHOT: begin
              count <= '0;
              out   <= 1'b1;
            end
            MODE_PERIODIC: begin
              count <= load;
              out   <= 1'b1;
              pulse <= 1'b1;
            end
            MODE_SQUARE: begin
              count <= load;
              out   <= ~out;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: rtl/counter_bank.sv
// Bank of NCH programmable down-counters with a shared write port and a
// combinational read-back of the selected channel's count.
module counter_bank
  import counter_bank_pkg::*;
#(
  parameter int NCH   = 3,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH-1:0]   ch_tick,
  input  logic             counter_we,
  input  logic             counter_sel,
  input  logic [CH_W-1:0]  counter_ch,
  input  logic [WIDTH-1:0] counter_val,
  output logic [NCH-1:0]   counter_OUT,
  output logic [WIDTH-1:0] counter_out
);

  logic [WIDTH-1:0] count [NCH];
  logic [NCH-1:0]   we_ch;

  // NOTE: outputs get a default before the loop so no latch is inferred;
  // an out-of-range channel matches nothing and so writes nowhere, reads 0.
  always_comb begin
    we_ch       = '0;
    counter_out = '0;
    for (int i = 0; i < NCH; i++) begin
      if (counter_ch == CH_W'(i)) begin
        we_ch[i]    = counter_we;
        counter_out = count[i];
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    counter_bank_ch #(.WIDTH(WIDTH)) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .tick_raw (ch_tick[g]),
      .we       (we_ch[g]),
      .sel      (counter_sel),
      .val      (counter_val),
      .count    (count[g]),
      .out      (counter_OUT[g])
    );
  end

endmodule
